bit_serializer: RTL
===================

Name: bit_serializer

Overview:
- Parallel-in, serial-out stage that sits directly upstream of the team's serial sequence detectors (e.g. the 0101 Mealy detector).
- Accepts a WIDTH-bit word through a valid/ready handshake and emits it one bit per clock on a registered serial line, together with a bit-valid qualifier.
- Supports back-to-back words with no gap cycle and a downstream stall (hold).

Parameters:
- WIDTH, 8, word width in bits; legal values are 2 to 32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- IDLE_LEVEL, 0, value driven on sout whenever sout_valid = 0 and no frame is in progress.

Ports:
- clock  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; 0 forces the reset state immediately.
- din  input  WIDTH  parallel word; sampled only on a handshake.
- din_valid  input  1  upstream has a word on din.
- din_ready  output  1  block can accept a word this cycle.
- hold  input  1  downstream stall; freezes shifting while high.
- sout  output  1  serial bit, registered.
- sout_valid  output  1  sout carries a real data bit this cycle.
- busy  output  1  a frame is in progress (SHIFT state).
- frame_done  output  1  one-cycle pulse marking the cycle the last bit of a word is presented.

Behaviour:
- Reset (reset = 0, asynchronous):
  - State goes to IDLE; shift register and counter clear to 0.
  - sout = IDLE_LEVEL; sout_valid = 0, busy = 0, frame_done = 0, din_ready = 0 while reset is low.
  - After reset deasserts, din_ready rises combinationally from IDLE.
  - Reset mid-frame aborts the word; remaining bits are discarded and never emitted.
- Handshake:
  - A transfer occurs on a rising edge where din_valid = 1 and din_ready = 1.
  - din_ready = 1 in IDLE.
  - din_ready = 1 in SHIFT only when the final bit is presented (bit counter = 0) and hold = 0.
  - din_ready = 0 otherwise.
  - din_valid while din_ready = 0 is ignored. Upstream must hold the word stable until it is accepted.
- State machine, 2 states:
  - IDLE -> SHIFT on a transfer.
  - SHIFT -> SHIFT on a transfer during the last-bit cycle (back-to-back).
  - SHIFT -> IDLE on the last-bit cycle with hold = 0 and no transfer.
  - SHIFT -> SHIFT, frozen, while hold = 1.
- Latency:
  - Word accepted at edge k: first bit appears on sout after edge k, with sout_valid = 1 in cycle k+1.
  - Bit i (0-based in send order) appears in cycle k+1+i, absent any hold.
  - The last bit appears in cycle k+WIDTH.
- Bit order:
  - MSB_FIRST = 1: send order is din[WIDTH-1] down to din[0].
  - MSB_FIRST = 0: send order is din[0] up to din[WIDTH-1].
- Counter:
  - Width is clog2(WIDTH).
  - Loaded with WIDTH-1 on a transfer; decrements once per non-held SHIFT cycle.
  - No wrap: reaching 0 ends the frame or reloads it.
- Hold:
  - hold = 1 in SHIFT freezes the shift register and counter; sout keeps its current bit.
  - sout_valid = 0 and din_ready = 0 for every held cycle.
  - The bit is re-presented with sout_valid = 1 once hold falls.
  - Each bit is emitted valid exactly once.
  - hold in IDLE has no effect.
- frame_done:
  - High for exactly the one non-held cycle in which the last bit is valid.
  - If hold is high during that cycle, frame_done is deferred together with the bit.
- Back-to-back:
  - A transfer on the last-bit cycle gives the next word's first bit in the following cycle.
  - sout_valid stays continuously high.
  - busy stays 1; frame_done pulses once per word.
- Idle outputs: in IDLE, sout = IDLE_LEVEL, sout_valid = 0, busy = 0.
- Registered outputs: sout, sout_valid, busy and frame_done come directly from flops. din_ready is the only combinational output.

Test Plan:
- Reset then din = 8'b0101_0101, one transfer, MSB_FIRST = 1 -> sout = 0,1,0,1,0,1,0,1 in cycles k+1..k+8 with sout_valid = 1; frame_done in cycle k+8 only; IDLE at k+9, sout = 0.
- Two words 8'hA5 then 8'h3C, din_valid held high -> 16 contiguous sout_valid cycles carrying 10100101 00111100; din_ready high only at cycles k and k+8; two frame_done pulses.
- 8'hF0 with hold high for 3 cycles after the 3rd bit -> sout holds 1 with sout_valid = 0 for 3 cycles; the 8 valid bits are still 11110000; frame_done is delayed by 3 cycles.
- Parameters WIDTH = 4, MSB_FIRST = 0, din = 4'b1101 -> sout = 1,0,1,1.
- reset pulsed low during the 5th bit of 8'hFF -> outputs return to reset values immediately; no further valid bits; the next word sends cleanly from its first bit.
- din_valid asserted while busy and not in the last bit -> no transfer, the in-flight word is unaltered, and the pending word is accepted on the last-bit cycle.

Source files
------------

// File: rtl/bit_serializer.sv
// Parallel-in, serial-out stage feeding the serial sequence detectors.
// A WIDTH-bit word is taken through a valid/ready handshake and sent one bit
// per clock on a registered serial line with a bit-valid qualifier. Words can
// follow each other with no gap, and a downstream hold stalls the stream.
//
// Hold is sampled on the clock edge. A cycle is "held" when hold was high at
// the edge that started it. In a held cycle, sout keeps the bit it already
// carried, sout_valid is low, and the bit that would have been presented is
// deferred until hold falls. As a result, every bit is qualified valid
// exactly once.
module bit_serializer #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             hold,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             frame_done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_LOAD = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE       = CW'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    count_q, count_d;
    logic             sout_q, sout_d;
    logic             soutValid_q, soutValid_d;
    logic             busy_q, busy_d;
    logic             frameDone_q, frameDone_d;

    logic             transfer;
    logic             firstBit;
    logic [WIDTH-1:0] loadRest;
    logic             nextBit;
    logic [WIDTH-1:0] shiftAdvance;

    // Ready is high in IDLE, or on the final bit of a frame when not stalled; forced low in reset.
    always_comb begin
        din_ready = 1'b0;
        if (reset) begin
            if (state_q == IDLE) begin
                din_ready = 1'b1;
            end else if ((count_q == '0) && !hold) begin
                din_ready = 1'b1;
            end
        end
    end

    assign transfer = din_valid && din_ready;

    // Bit-order steering: choose which end of the word leaves first and which way the register shifts.
    always_comb begin
        if (MSB_FIRST) begin
            firstBit     = din[WIDTH-1];
            loadRest     = din << 1;
            nextBit      = shift_q[WIDTH-1];
            shiftAdvance = shift_q << 1;
        end else begin
            firstBit     = din[0];
            loadRest     = din >> 1;
            nextBit      = shift_q[0];
            shiftAdvance = shift_q >> 1;
        end
    end

    // Next-state and next-output logic; the counter holds the number of bits still to present after the current one.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        count_d     = count_q;
        sout_d      = sout_q;
        soutValid_d = 1'b0;
        busy_d      = busy_q;
        frameDone_d = 1'b0;

        case (state_q)
            IDLE: begin
                sout_d = IDLE_LEVEL;
                busy_d = 1'b0;
                if (transfer) begin
                    state_d     = SHIFT;
                    shift_d     = loadRest;
                    count_d     = LAST_LOAD;
                    sout_d      = firstBit;
                    soutValid_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            SHIFT: begin
                if (hold) begin
                    state_d = SHIFT;
                end else if (count_q != '0) begin
                    shift_d     = shiftAdvance;
                    count_d     = count_q - ONE;
                    sout_d      = nextBit;
                    soutValid_d = 1'b1;
                    frameDone_d = (count_q == ONE);
                end else if (transfer) begin
                    shift_d     = loadRest;
                    count_d     = LAST_LOAD;
                    sout_d      = firstBit;
                    soutValid_d = 1'b1;
                    busy_d      = 1'b1;
                end else begin
                    state_d = IDLE;
                    sout_d  = IDLE_LEVEL;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                sout_d  = IDLE_LEVEL;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers; reset aborts any frame in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            count_q     <= '0;
            sout_q      <= IDLE_LEVEL;
            soutValid_q <= 1'b0;
            busy_q      <= 1'b0;
            frameDone_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            count_q     <= count_d;
            sout_q      <= sout_d;
            soutValid_q <= soutValid_d;
            busy_q      <= busy_d;
            frameDone_q <= frameDone_d;
        end
    end

    assign sout       = sout_q;
    assign sout_valid = soutValid_q;
    assign busy       = busy_q;
    assign frame_done = frameDone_q;

endmodule
